// File: rtl/ysyx_22050078_pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use bubbles, EX redirects,
// LSU memory-wait freeze with timeout, and saturating stall/flush perf counters.
module ysyx_22050078_pipe_hazard_ctrl #(
  parameter int REG_AW      = 5,
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [REG_AW-1:0] i_id_rs1_addr,
  input  logic              i_id_rs1_ren,
  input  logic [REG_AW-1:0] i_id_rs2_addr,
  input  logic              i_id_rs2_ren,
  input  logic [REG_AW-1:0] i_ex_rd_addr,
  input  logic              i_ex_rdwen,
  input  logic              i_ex_lden,
  input  logic              i_ex_redirect,
  input  logic              i_ls_lden,
  input  logic              i_ls_sten,
  input  logic              i_mem_ready,
  output logic              o_pc_wen,
  output logic              o_ifid_wen,
  output logic              o_ifid_flush,
  output logic              o_idex_wen,
  output logic              o_idex_flush,
  output logic              o_exls_wen,
  output logic              o_lswb_flush,
  output logic              o_mem_err,
  output logic [CNT_W-1:0]  o_stall_cnt,
  output logic [CNT_W-1:0]  o_flush_cnt
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    ERR     = 2'd2
  } state_e;

  localparam logic [15:0] TMO_MAX = 16'(MEM_TIMEOUT);

  state_e           state_q, state_d;
  logic [15:0]      tmo_q, tmo_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic in_err;
  logic memop;
  logic memstall;
  logic ld_use;
  logic redirect_act;
  logic ld_use_act;
  logic stall_cycle;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] one;
    one = {{(CNT_W-1){1'b0}}, 1'b1};
    return (&v) ? v : v + one;
  endfunction

  // Hazard classification; lower-priority conditions are masked by higher ones.
  always_comb begin
    in_err   = (state_q == ERR);
    memop    = i_ls_lden | i_ls_sten;
    memstall = memop & ~i_mem_ready & ~in_err;
    ld_use   = i_ex_lden & i_ex_rdwen & (i_ex_rd_addr != '0) &
               ((i_id_rs1_ren & (i_id_rs1_addr == i_ex_rd_addr)) |
                (i_id_rs2_ren & (i_id_rs2_addr == i_ex_rd_addr)));
    redirect_act = ~in_err & ~memstall & i_ex_redirect;
    ld_use_act   = ~in_err & ~memstall & ~i_ex_redirect & ld_use;
    stall_cycle  = in_err | memstall | ld_use_act;
  end

  always_comb begin
    o_pc_wen     = 1'b0;
    o_ifid_wen   = 1'b0;
    o_ifid_flush = 1'b0;
    o_idex_wen   = 1'b0;
    o_idex_flush = 1'b0;
    o_exls_wen   = 1'b0;
    o_lswb_flush = 1'b0;
    if (i_rst_n) begin
      if (in_err || memstall) begin
        // Freeze everything upstream; bubble LS/WB so the held LS op retires once.
        o_lswb_flush = 1'b1;
      end else if (redirect_act) begin
        o_pc_wen     = 1'b1;
        o_ifid_wen   = 1'b1;
        o_ifid_flush = 1'b1;
        o_idex_wen   = 1'b1;
        o_idex_flush = 1'b1;
        o_exls_wen   = 1'b1;
      end else if (ld_use_act) begin
        o_idex_wen   = 1'b1;
        o_idex_flush = 1'b1;
        o_exls_wen   = 1'b1;
      end else begin
        o_pc_wen     = 1'b1;
        o_ifid_wen   = 1'b1;
        o_idex_wen   = 1'b1;
        o_exls_wen   = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    tmo_d       = tmo_q;
    stall_cnt_d = stall_cycle  ? sat_inc(stall_cnt_q) : stall_cnt_q;
    flush_cnt_d = redirect_act ? sat_inc(flush_cnt_q) : flush_cnt_q;
    case (state_q)
      RUN: begin
        if (memstall) begin
          state_d = MEMWAIT;
          tmo_d   = 16'd1;
        end
      end
      MEMWAIT: begin
        if (i_mem_ready) begin
          state_d = RUN;
          tmo_d   = '0;
        end else if (tmo_q >= TMO_MAX) begin
          state_d = ERR;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      ERR:     state_d = ERR;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= RUN;
      tmo_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign o_mem_err   = (state_q == ERR);
  assign o_stall_cnt = stall_cnt_q;
  assign o_flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_ysyx_22050078_pipe_hazard_ctrl.sv
// Bench for the hazard controller: directed scenarios with literal expectations,
// then random traffic checked every cycle against a rule-level model.
module tb_ysyx_22050078_pipe_hazard_ctrl;

  localparam int AW  = 5;
  localparam int TMO = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [AW-1:0] rs1, rs2, rd;
  logic          rs1_ren, rs2_ren, ex_rdwen, ex_lden, ex_redir;
  logic          ls_lden, ls_sten, mem_ready;

  logic        a_pc, a_ifw, a_iff, a_idw, a_idf, a_exw, a_lsf, a_err;
  logic [15:0] a_stall, a_flush;
  logic        b_pc, b_ifw, b_iff, b_idw, b_idf, b_exw, b_lsf, b_err;
  logic [3:0]  b_stall, b_flush;

  ysyx_22050078_pipe_hazard_ctrl #(.REG_AW(AW), .CNT_W(16), .MEM_TIMEOUT(TMO)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_id_rs1_addr(rs1), .i_id_rs1_ren(rs1_ren),
    .i_id_rs2_addr(rs2), .i_id_rs2_ren(rs2_ren),
    .i_ex_rd_addr(rd), .i_ex_rdwen(ex_rdwen), .i_ex_lden(ex_lden),
    .i_ex_redirect(ex_redir), .i_ls_lden(ls_lden), .i_ls_sten(ls_sten),
    .i_mem_ready(mem_ready),
    .o_pc_wen(a_pc), .o_ifid_wen(a_ifw), .o_ifid_flush(a_iff),
    .o_idex_wen(a_idw), .o_idex_flush(a_idf), .o_exls_wen(a_exw),
    .o_lswb_flush(a_lsf), .o_mem_err(a_err),
    .o_stall_cnt(a_stall), .o_flush_cnt(a_flush)
  );

  ysyx_22050078_pipe_hazard_ctrl #(.REG_AW(AW), .CNT_W(4), .MEM_TIMEOUT(TMO)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_id_rs1_addr(rs1), .i_id_rs1_ren(rs1_ren),
    .i_id_rs2_addr(rs2), .i_id_rs2_ren(rs2_ren),
    .i_ex_rd_addr(rd), .i_ex_rdwen(ex_rdwen), .i_ex_lden(ex_lden),
    .i_ex_redirect(ex_redir), .i_ls_lden(ls_lden), .i_ls_sten(ls_sten),
    .i_mem_ready(mem_ready),
    .o_pc_wen(b_pc), .o_ifid_wen(b_ifw), .o_ifid_flush(b_iff),
    .o_idex_wen(b_idw), .o_idex_flush(b_idf), .o_exls_wen(b_exw),
    .o_lswb_flush(b_lsf), .o_mem_err(b_err),
    .o_stall_cnt(b_stall), .o_flush_cnt(b_flush)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- rule-level reference model ----------------
  bit m_started = 0;
  bit m_err     = 0;
  int m_wait    = 0;   // consecutive memory-stall cycles so far
  int m_stall_n = 0;   // unsaturated event totals
  int m_flush_n = 0;

  function automatic bit f_ld_use();
    return ex_lden && ex_rdwen && rd != 0 &&
           ((rs1_ren && rs1 == rd) || (rs2_ren && rs2 == rd));
  endfunction

  function automatic bit f_memstall();
    return (ls_lden || ls_sten) && !mem_ready && !m_err;
  endfunction

  // {pc_wen, ifid_wen, ifid_flush, idex_wen, idex_flush, exls_wen, lswb_flush}
  function automatic logic [6:0] f_ctrl();
    if (!rst_n)        return 7'b0000000;
    if (m_err)         return 7'b0000001;
    if (f_memstall())  return 7'b0000001;
    if (ex_redir)      return 7'b1111110;
    if (f_ld_use())    return 7'b0001110;
    return 7'b1101010;
  endfunction

  function automatic longint sat(input int n, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (n > mx) ? mx : n;
  endfunction

  always @(posedge clk) begin
    bit ms, rd_act, lu_act;
    m_started <= 1'b1;
    if (!rst_n) begin
      m_err = 0; m_wait = 0; m_stall_n = 0; m_flush_n = 0;
    end else begin
      ms     = f_memstall();
      rd_act = !m_err && !ms && ex_redir;
      lu_act = !m_err && !ms && !ex_redir && f_ld_use();
      if (m_err || ms || lu_act) m_stall_n++;
      if (rd_act) m_flush_n++;
      if (!m_err) begin
        if (ms) begin
          m_wait++;
          if (m_wait > TMO) m_err = 1;
        end else begin
          m_wait = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_started) begin
      chk("ctrl_a", {a_pc, a_ifw, a_iff, a_idw, a_idf, a_exw, a_lsf}, f_ctrl());
      chk("ctrl_b", {b_pc, b_ifw, b_iff, b_idw, b_idf, b_exw, b_lsf}, f_ctrl());
      chk("mem_err_a", a_err, m_err);
      chk("mem_err_b", b_err, m_err);
      chk("stall_a", a_stall, sat(m_stall_n, 16));
      chk("stall_b", b_stall, sat(m_stall_n, 4));
      chk("flush_a", a_flush, sat(m_flush_n, 16));
      chk("flush_b", b_flush, sat(m_flush_n, 4));
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    rs1 = '0; rs2 = '0; rd = '0;
    rs1_ren = 0; rs2_ren = 0; ex_rdwen = 0; ex_lden = 0; ex_redir = 0;
    ls_lden = 0; ls_sten = 0; mem_ready = 0;
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic set_lu(input logic [AW-1:0] r);
    ex_lden = 1; ex_rdwen = 1; rd = r; rs2_ren = 1; rs2 = r;
  endtask

  task automatic do_reset();
    rst_n = 0; idle();
    nxt();
    chk("rst_pc_wen", a_pc, 0);
    rst_n = 1;
  endtask

  initial begin
    bit pending, slow;
    rst_n = 0; idle();
    repeat (2) nxt();
    rst_n = 1;

    // Idle after reset
    @(negedge clk);
    chk("t1_pc_wen", a_pc, 1); chk("t1_ifid_flush", a_iff, 0);
    chk("t1_stall", a_stall, 0); chk("t1_flush", a_flush, 0); chk("t1_err", a_err, 0);

    // Load-use on rs2, then rd=x0
    nxt(); set_lu(5'd5);
    @(negedge clk);
    chk("t2_pc_wen", a_pc, 0); chk("t2_ifid_wen", a_ifw, 0); chk("t2_idex_flush", a_idf, 1);
    nxt(); idle();
    @(negedge clk); chk("t2_stall", a_stall, 1);
    nxt(); set_lu(5'd0);
    @(negedge clk); chk("t2_x0_pc_wen", a_pc, 1);
    nxt(); idle();
    @(negedge clk); chk("t2_x0_stall", a_stall, 1);

    // Redirect alone, then redirect with load-use
    nxt(); ex_redir = 1;
    @(negedge clk);
    chk("t3_ifid_flush", a_iff, 1); chk("t3_idex_flush", a_idf, 1); chk("t3_pc_wen", a_pc, 1);
    nxt(); idle();
    @(negedge clk); chk("t3_flush", a_flush, 1);
    nxt(); ex_redir = 1; set_lu(5'd7);
    @(negedge clk); chk("t3_both_pc_wen", a_pc, 1); chk("t3_both_ifid_wen", a_ifw, 1);
    nxt(); idle();
    @(negedge clk); chk("t3_both_flush", a_flush, 2); chk("t3_both_stall", a_stall, 1);

    // Memory wait of three cycles
    for (int i = 0; i < 3; i++) begin
      nxt(); ls_lden = 1; mem_ready = 0;
      @(negedge clk);
      chk("t4_pc_wen", a_pc, 0); chk("t4_exls_wen", a_exw, 0); chk("t4_lswb_flush", a_lsf, 1);
    end
    nxt(); mem_ready = 1;
    @(negedge clk); chk("t4_done_pc_wen", a_pc, 1); chk("t4_done_lswb", a_lsf, 0);
    nxt(); idle();
    @(negedge clk); chk("t4_stall", a_stall, 4);

    // Timeout into ERR, ready has no effect, reset recovers
    nxt(); ls_sten = 1; mem_ready = 0;
    repeat (5) nxt();
    @(negedge clk);
    chk("t5_err", a_err, 1); chk("t5_pc_wen", a_pc, 0); chk("t5_idex_wen", a_idw, 0);
    chk("t5_lswb", a_lsf, 1);
    nxt(); mem_ready = 1;
    @(negedge clk); chk("t5_err_hold", a_err, 1); chk("t5_hold_pc_wen", a_pc, 0);
    nxt(); do_reset();
    @(negedge clk);
    chk("t5_rst_err", a_err, 0); chk("t5_rst_pc_wen", a_pc, 1); chk("t5_rst_stall", a_stall, 0);

    // Saturation of the narrow counter
    for (int i = 0; i < 20; i++) begin nxt(); set_lu(5'd9); end
    nxt(); idle();
    @(negedge clk); chk("t6_stall_b", b_stall, 15); chk("t6_stall_a", a_stall, 20);
    nxt(); set_lu(5'd9);
    nxt(); idle();
    @(negedge clk); chk("t6_hold_b", b_stall, 15);

    // Random traffic; an LS op stays in place until its memory completes
    nxt(); do_reset();
    slow = 0;
    for (int c = 0; c < 4000; c++) begin
      pending = rst_n && (ls_lden || ls_sten) && !mem_ready;
      nxt();
      if ($urandom_range(99) < 2 || (m_err && $urandom_range(7) == 0)) begin
        rst_n = 0;
      end else begin
        rst_n = 1;
      end
      rs1 = AW'($urandom_range(3)); rs2 = AW'($urandom_range(3)); rd = AW'($urandom_range(3));
      rs1_ren = 1'($urandom); rs2_ren = 1'($urandom);
      ex_rdwen = 1'($urandom); ex_lden = 1'($urandom);
      ex_redir = ($urandom_range(4) == 0);
      if (!(pending && rst_n)) begin
        ls_lden = 0; ls_sten = 0;
        if ($urandom_range(2) == 0) begin
          if ($urandom_range(1) == 0) ls_lden = 1; else ls_sten = 1;
          slow = ($urandom_range(5) == 0);
        end
      end
      mem_ready = slow ? ($urandom_range(19) == 0) : ($urandom_range(1) == 0);
    end
    nxt(); idle(); rst_n = 1;
    @(negedge clk); @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_22050078_pipe_hazard_ctrl.md
Name: ysyx_22050078_pipe_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage pipeline. It drives the write-enable and flush inputs of the PC and of the IF/ID, ID/EX, EX/LS and LS/WB pipeline registers.
- It resolves three conditions: load-use hazards, EX-stage control redirects, and multi-cycle LSU memory waits with a timeout.
- It keeps saturating stall and flush event counters for performance debug.

Parameters:
- REG_AW, 5, register address width.
- CNT_W, 32, perf counter width.
- MEM_TIMEOUT, 255, maximum MEMWAIT cycles before the error state; legal range 1..2^16-1.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  synchronous active-low reset
- i_id_rs1_addr  in  REG_AW  ID-stage rs1 index
- i_id_rs1_ren  in  1  ID instruction reads rs1
- i_id_rs2_addr  in  REG_AW  ID-stage rs2 index
- i_id_rs2_ren  in  1  ID instruction reads rs2
- i_ex_rd_addr  in  REG_AW  EX-stage destination index
- i_ex_rdwen  in  1  EX instruction writes rd
- i_ex_lden  in  1  EX instruction is a load
- i_ex_redirect  in  1  EX resolved a taken branch/jump; PC must load the target
- i_ls_lden  in  1  LS-stage load
- i_ls_sten  in  1  LS-stage store
- i_mem_ready  in  1  data memory completes the LS access this cycle
- o_pc_wen  out  1  PC update enable
- o_ifid_wen  out  1  IF/ID register enable
- o_ifid_flush  out  1  IF/ID bubble insert
- o_idex_wen  out  1  ID/EX register enable
- o_idex_flush  out  1  ID/EX bubble insert
- o_exls_wen  out  1  EX/LS register enable
- o_lswb_flush  out  1  LS/WB bubble insert
- o_mem_err  out  1  sticky memory-timeout error
- o_stall_cnt  out  CNT_W  cycles with any stall asserted
- o_flush_cnt  out  CNT_W  redirect flush events

Behaviour:
- FSM states: RUN, MEMWAIT, ERR. State, timeout counter and perf counters are registered.
- Control outputs are combinational from the current inputs and the current state; they act in the same cycle.
- While i_rst_n=0 at a clock edge: next state=RUN, timeout counter=0, o_stall_cnt=0, o_flush_cnt=0, o_mem_err=0.
- While i_rst_n=0, control outputs are all wen=0 and all flush=0.
- A mid-operation reset abandons MEMWAIT/ERR immediately.
- memop = i_ls_lden | i_ls_sten.
- memstall = memop & ~i_mem_ready, in RUN or MEMWAIT.
- Priority: ERR > memstall > redirect > load-use > normal.
- Normal: every wen=1, every flush=0.
- memstall:
  - pc, ifid, idex and exls wen=0; no other flush.
  - o_lswb_flush=1, so no duplicate writeback occurs.
  - Redirect and load-use are ignored that cycle; they re-evaluate once the freeze ends because the instructions stay in place.
- Redirect (i_ex_redirect=1, no memstall):
  - o_pc_wen=1, o_ifid_flush=1, o_idex_flush=1, other wen=1.
  - o_flush_cnt increments by 1, saturating at all-ones.
- Load-use (no memstall, no redirect):
  - Condition: i_ex_lden & i_ex_rdwen & i_ex_rd_addr!=0 & ((i_id_rs1_ren & rs1==rd) | (i_id_rs2_ren & rs2==rd)).
  - Response: o_pc_wen=0, o_ifid_wen=0, o_idex_flush=1, o_exls_wen=1. Exactly one bubble is inserted.
- Register x0 never causes a load-use hazard.
- Stall cycle: any cycle with memstall or load-use in a non-ERR state, or any cycle in ERR. o_stall_cnt increments by 1 per stall cycle, saturating.
- Transitions:
  - RUN -> MEMWAIT when memstall; the timeout counter loads 1.
  - MEMWAIT stays while ~i_mem_ready; the counter increments.
  - MEMWAIT -> RUN when i_mem_ready. That cycle is a normal, non-stall cycle. If memop is still asserted on the next instruction, the RUN rule applies again.
  - MEMWAIT -> ERR when the counter reaches MEM_TIMEOUT and ~i_mem_ready.
  - ERR: o_mem_err=1; all wen=0; o_lswb_flush=1; only exit is reset.
- memop with i_mem_ready=1 in the same cycle is single-cycle: no stall, state stays RUN.
- Counter saturation applies to both perf counters.

Test Plan:
1. Reset, then idle inputs with i_rst_n=1 -> all wen=1, all flush=0, both counters=0, state RUN.
2. Load-use: i_ex_lden=1, i_ex_rdwen=1, i_ex_rd_addr=5, i_id_rs2_ren=1, i_id_rs2_addr=5 for 1 cycle -> o_pc_wen=0, o_ifid_wen=0, o_idex_flush=1, o_stall_cnt=1. Repeat with rd=0 -> no stall.
3. Redirect: i_ex_redirect=1 for 1 cycle -> o_ifid_flush=1, o_idex_flush=1, o_pc_wen=1, o_flush_cnt=1. Redirect plus load-use conditions in the same cycle -> redirect response only.
4. Memory wait: i_ls_lden=1 with i_mem_ready low for 3 cycles then high -> 3 cycles with pc/ifid/idex/exls wen=0 and o_lswb_flush=1; the 4th cycle is normal; o_stall_cnt=3.
5. Timeout with MEM_TIMEOUT=4: i_ls_sten=1, i_mem_ready held 0 -> after 4 MEMWAIT cycles the state is ERR, o_mem_err=1, all wen=0. Later i_mem_ready=1 has no effect. Reset returns to RUN and clears o_mem_err.
6. Saturation with CNT_W=4: 20 consecutive load-use cycles -> o_stall_cnt=15 and holds.
